// File: rtl/csr_reg_pkg.sv
// rtl/csr_reg_pkg.sv - shared CSR addresses, masks, state bundle and read decode
package csr_reg_pkg;

  // Machine-mode CSR addresses (low 12 bits; upper 20 address bits must be zero)
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP    = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK      = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK    = 32'hFFFF_FFFC;
  localparam int          MSTATUS_MIE_BIT = 3;

  typedef struct packed {
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;
  } csr_state_t;

  // True when a write port targets exactly this CSR
  function automatic logic csr_hit(input logic we, input logic [31:0] addr,
                                   input logic [11:0] target);
    return we && (addr[31:12] == 20'h0) && (addr[11:0] == target);
  endfunction

  // Combinational read decode; anything outside the map reads as zero
  function automatic logic [31:0] csr_read(input csr_state_t s, input logic [31:0] addr,
                                           input logic [31:0] misa);
    logic [31:0] v;
    v = 32'h0;
    if (addr[31:12] == 20'h0) begin
      case (addr[11:0])
        CSR_MSTATUS:                 v = s.mstatus;
        CSR_MISA:                    v = misa;
        CSR_MIE:                     v = s.mie;
        CSR_MTVEC:                   v = s.mtvec;
        CSR_MSCRATCH:                v = s.mscratch;
        CSR_MEPC:                    v = s.mepc;
        CSR_MCAUSE:                  v = s.mcause;
        CSR_MCYCLE,   CSR_CYCLE:     v = s.mcycle[31:0];
        CSR_MCYCLEH,  CSR_CYCLEH:    v = s.mcycle[63:32];
        CSR_MINSTRET, CSR_INSTRET:   v = s.minstret[31:0];
        CSR_MINSTRETH, CSR_INSTRETH: v = s.minstret[63:32];
        default:                     v = 32'h0;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable and per-half load
module csr_counter64
  import csr_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_load_lo,
  input  logic        i_load_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  // Loads take priority and suppress the increment; the full-width add carries into the high half and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 64'h0;
    end else if (i_load_lo || i_load_hi) begin
      if (i_load_lo) r_count[31:0]  <= i_wdata_lo;
      if (i_load_hi) r_count[63:32] <= i_wdata_hi;
    end else if (i_inc) begin
      r_count <= r_count + 64'h1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_reg.sv
// rtl/csr_reg.sv - machine-mode CSR file with execute and interrupt-controller ports
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  input  logic [31:0] clint_raddr_i,
  output logic [31:0] clint_rdata_o,
  input  logic        inst_retire_i,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o,
  output logic        global_interrupt_en_o
);

  logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [63:0] w_mcycle, w_minstret;
  logic        w_ex_wr, w_cl_wr;
  csr_state_t  w_state;

  // The interrupt controller wins a same-address collision, so the execute write is dropped
  assign w_cl_wr = clint_we_i && (clint_waddr_i[31:12] == 20'h0);
  assign w_ex_wr = we_i && (waddr_i[31:12] == 20'h0) &&
                   !(clint_we_i && (clint_waddr_i == waddr_i));

  logic w_cyc_lo_cl, w_cyc_hi_cl, w_ir_lo_cl, w_ir_hi_cl;
  logic w_cyc_lo_ex, w_cyc_hi_ex, w_ir_lo_ex, w_ir_hi_ex;

  assign w_cyc_lo_cl = csr_hit(w_cl_wr, clint_waddr_i, CSR_MCYCLE);
  assign w_cyc_hi_cl = csr_hit(w_cl_wr, clint_waddr_i, CSR_MCYCLEH);
  assign w_ir_lo_cl  = csr_hit(w_cl_wr, clint_waddr_i, CSR_MINSTRET);
  assign w_ir_hi_cl  = csr_hit(w_cl_wr, clint_waddr_i, CSR_MINSTRETH);
  assign w_cyc_lo_ex = csr_hit(w_ex_wr, waddr_i, CSR_MCYCLE);
  assign w_cyc_hi_ex = csr_hit(w_ex_wr, waddr_i, CSR_MCYCLEH);
  assign w_ir_lo_ex  = csr_hit(w_ex_wr, waddr_i, CSR_MINSTRET);
  assign w_ir_hi_ex  = csr_hit(w_ex_wr, waddr_i, CSR_MINSTRETH);

  csr_counter64 u_mcycle (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (1'b1),
    .i_load_lo  (w_cyc_lo_cl || w_cyc_lo_ex),
    .i_load_hi  (w_cyc_hi_cl || w_cyc_hi_ex),
    .i_wdata_lo (w_cyc_lo_cl ? clint_wdata_i : wdata_i),
    .i_wdata_hi (w_cyc_hi_cl ? clint_wdata_i : wdata_i),
    .o_count    (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (inst_retire_i),
    .i_load_lo  (w_ir_lo_cl || w_ir_lo_ex),
    .i_load_hi  (w_ir_hi_cl || w_ir_hi_ex),
    .i_wdata_lo (w_ir_lo_cl ? clint_wdata_i : wdata_i),
    .i_wdata_hi (w_ir_hi_cl ? clint_wdata_i : wdata_i),
    .o_count    (w_minstret)
  );

  // Commit both ports' writes to the plain registers; masks are applied on the way in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus  <= MSTATUS_MPP;
      r_mie      <= 32'h0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
    end else begin
      if (w_ex_wr) begin
        case (waddr_i[11:0])
          CSR_MSTATUS:  r_mstatus  <= (wdata_i & MSTATUS_WMASK) | MSTATUS_MPP;
          CSR_MIE:      r_mie      <= wdata_i & MIE_WMASK;
          CSR_MTVEC:    r_mtvec    <= wdata_i & ALIGN4_MASK;
          CSR_MSCRATCH: r_mscratch <= wdata_i;
          CSR_MEPC:     r_mepc     <= wdata_i & ALIGN4_MASK;
          CSR_MCAUSE:   r_mcause   <= wdata_i;
          default:      ;
        endcase
      end
      if (w_cl_wr) begin
        case (clint_waddr_i[11:0])
          CSR_MSTATUS:  r_mstatus  <= (clint_wdata_i & MSTATUS_WMASK) | MSTATUS_MPP;
          CSR_MIE:      r_mie      <= clint_wdata_i & MIE_WMASK;
          CSR_MTVEC:    r_mtvec    <= clint_wdata_i & ALIGN4_MASK;
          CSR_MSCRATCH: r_mscratch <= clint_wdata_i;
          CSR_MEPC:     r_mepc     <= clint_wdata_i & ALIGN4_MASK;
          CSR_MCAUSE:   r_mcause   <= clint_wdata_i;
          default:      ;
        endcase
      end
    end
  end

  // Gather current state for the shared read decode
  always_comb begin
    w_state          = '0;
    w_state.mstatus  = r_mstatus;
    w_state.mie      = r_mie;
    w_state.mtvec    = r_mtvec;
    w_state.mscratch = r_mscratch;
    w_state.mepc     = r_mepc;
    w_state.mcause   = r_mcause;
    w_state.mcycle   = w_mcycle;
    w_state.minstret = w_minstret;
  end

  assign rdata_o       = csr_read(w_state, raddr_i, MISA_VAL);
  assign clint_rdata_o = csr_read(w_state, clint_raddr_i, MISA_VAL);

  assign csr_mtvec_o           = r_mtvec;
  assign csr_mepc_o            = r_mepc;
  assign csr_mstatus_o         = r_mstatus;
  assign global_interrupt_en_o = r_mstatus[MSTATUS_MIE_BIT];

endmodule

// File: tb/tb_csr_reg.sv
// tb/tb_csr_reg.sv - self-checking bench for csr_reg against a behavioural model
module tb_csr_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_i, clint_we_i, inst_retire_i;
  logic [31:0] waddr_i, wdata_i, raddr_i, clint_waddr_i, clint_wdata_i, clint_raddr_i;
  logic [31:0] rdata_o, clint_rdata_o, csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
  logic        global_interrupt_en_o;

  int n_checks = 0;
  int n_fail   = 0;

  csr_reg dut (
    .clk(clk), .rst_n(rst_n),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .clint_we_i(clint_we_i), .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
    .clint_raddr_i(clint_raddr_i), .clint_rdata_o(clint_rdata_o),
    .inst_retire_i(inst_retire_i),
    .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o), .csr_mstatus_o(csr_mstatus_o),
    .global_interrupt_en_o(global_interrupt_en_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural CSR contents
  bit          m_valid = 0;
  bit          m_mie_bit, m_mpie_bit;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret, cyc_v, ir_v;
  bit          cyc_w, ir_w;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:12] != 0) return 32'h0;
    case (a[11:0])
      12'h300: return 32'h1800 | (32'(m_mie_bit) << 3) | (32'(m_mpie_bit) << 7);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31:12] != 0) return;
    case (a[11:0])
      12'h300: begin m_mie_bit = d[3]; m_mpie_bit = d[7]; end
      12'h304: m_mie = d & 32'h888;
      12'h305: m_mtvec = {d[31:2], 2'b00};
      12'h340: m_mscratch = d;
      12'h341: m_mepc = {d[31:2], 2'b00};
      12'h342: m_mcause = d;
      12'hB00: begin cyc_v[31:0]  = d; cyc_w = 1; end
      12'hB80: begin cyc_v[63:32] = d; cyc_w = 1; end
      12'hB02: begin ir_v[31:0]   = d; ir_w = 1; end
      12'hB82: begin ir_v[63:32]  = d; ir_w = 1; end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mie_bit = 0; m_mpie_bit = 0; m_mie = 0; m_mtvec = 0;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
      m_valid = 1;
    end else if (m_valid) begin
      cyc_w = 0; ir_w = 0; cyc_v = m_cycle; ir_v = m_instret;
      if (we_i && !(clint_we_i && clint_waddr_i == waddr_i)) m_write(waddr_i, wdata_i);
      if (clint_we_i) m_write(clint_waddr_i, clint_wdata_i);
      m_cycle   = cyc_w ? cyc_v : m_cycle + 64'd1;
      m_instret = ir_w ? ir_v : m_instret + (inst_retire_i ? 64'd1 : 64'd0);
    end
  end

  // Every cycle once the model is live: both read ports and all exports
  always @(negedge clk) begin
    if (m_valid) begin
      check("rdata", rdata_o, m_read(raddr_i));
      check("clint_rdata", clint_rdata_o, m_read(clint_raddr_i));
      check("mtvec_o", csr_mtvec_o, m_mtvec);
      check("mepc_o", csr_mepc_o, m_mepc);
      check("mstatus_o", csr_mstatus_o, m_read(32'h300));
      check("gie", {31'b0, global_interrupt_en_o}, {31'b0, m_mie_bit});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 0; clint_we_i = 0; inst_retire_i = 0;
  endtask

  task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; wdata_i = d;
  endtask

  task automatic cl_wr(input logic [31:0] a, input logic [31:0] d);
    clint_we_i = 1; clint_waddr_i = a; clint_wdata_i = d;
  endtask

  initial begin
    rst_n = 1; idle();
    waddr_i = 0; wdata_i = 0; clint_waddr_i = 0; clint_wdata_i = 0;
    raddr_i = 32'h300; clint_raddr_i = 32'h305;
    #3 rst_n = 0;
    #1;
    check("reset mstatus read", rdata_o, 32'h1800);
    check("reset mtvec read", clint_rdata_o, 32'h0);
    check("reset gie", {31'b0, global_interrupt_en_o}, 32'h0);
    check("reset mstatus_o", csr_mstatus_o, 32'h1800);
    raddr_i = 32'h301; #1;
    check("misa", rdata_o, 32'h4000_0100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // mstatus mask and no bypass
    raddr_i = 32'h300; ex_wr(32'h300, 32'hFFFF_FFFF); #2;
    check("mstatus pre-commit", rdata_o, 32'h1800);
    step(); idle(); #2;
    check("mstatus masked", rdata_o, 32'h1888);
    check("gie set", {31'b0, global_interrupt_en_o}, 32'h1);

    // mtvec alignment and mie mask
    ex_wr(32'h305, 32'h8000_0003); cl_wr(32'h304, 32'hFFFF_FFFF);
    step(); idle(); raddr_i = 32'h305; clint_raddr_i = 32'h304; #2;
    check("mtvec aligned", rdata_o, 32'h8000_0000);
    check("mie masked", clint_rdata_o, 32'h888);

    // same-address conflict, clint wins
    ex_wr(32'h341, 32'h100); cl_wr(32'h341, 32'h200);
    step(); idle(); raddr_i = 32'h341; #2;
    check("mepc conflict", rdata_o, 32'h200);

    // different addresses, both commit
    ex_wr(32'h340, 32'd5); cl_wr(32'h342, 32'd11);
    step(); idle(); raddr_i = 32'h340; clint_raddr_i = 32'h342; #2;
    check("mscratch dual", rdata_o, 32'd5);
    check("mcause dual", clint_rdata_o, 32'd11);

    // read timing
    ex_wr(32'h340, 32'hA5A5_A5A5); clint_raddr_i = 32'h340; #2;
    check("mscratch old ex", rdata_o, 32'd5);
    check("mscratch old clint", clint_rdata_o, 32'd5);
    step(); idle(); #2;
    check("mscratch new ex", rdata_o, 32'hA5A5_A5A5);
    check("mscratch new clint", clint_rdata_o, 32'hA5A5_A5A5);

    // cycle carry across the halves; cycle alias is read-only
    ex_wr(32'hB00, 32'hFFFF_FFFE); cl_wr(32'hB80, 32'h0);
    step(); idle(); raddr_i = 32'hB00; clint_raddr_i = 32'hB80; #2;
    check("mcycle loaded lo", rdata_o, 32'hFFFF_FFFE);
    step(); step(); raddr_i = 32'hC00; clint_raddr_i = 32'hC80; #2;
    check("cycle carry lo", rdata_o, 32'h0);
    check("cycle carry hi", clint_rdata_o, 32'h1);
    ex_wr(32'hC00, 32'h1234);
    step(); idle(); #2;
    check("cycle ro lo", rdata_o, 32'h1);
    check("cycle ro hi", clint_rdata_o, 32'h1);

    // unmapped addresses: reads zero, writes ignored
    raddr_i = 32'h7C0; clint_raddr_i = 32'h0000_1300; #1;
    check("unmapped 7c0", rdata_o, 32'h0);
    check("unmapped 1300", clint_rdata_o, 32'h0);
    ex_wr(32'h7C0, 32'hFFFF_FFFF); cl_wr(32'h0000_1300, 32'h0);
    step(); idle(); raddr_i = 32'h300; #2;
    check("mstatus untouched", rdata_o, 32'h1888);

    // minstret: write beats retire, then three retires
    ex_wr(32'hB02, 32'h0); cl_wr(32'hB82, 32'h0); inst_retire_i = 1;
    step(); idle(); raddr_i = 32'hB02; #2;
    check("minstret write wins", rdata_o, 32'h0);
    inst_retire_i = 1;
    repeat (3) step();
    idle(); raddr_i = 32'hC02; clint_raddr_i = 32'hC82; #2;
    check("instret 3", rdata_o, 32'd3);
    check("instreth 0", clint_rdata_o, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
